// File: rtl/reg_bank_pkg.sv
// ---------------------------------------------------------------------------
// reg_bank_pkg
// Shared definitions for the register-bank write path: the data width of a
// bank register and the state encoding of the write arbiter FSM.
// No ports (package).
// ---------------------------------------------------------------------------
package reg_bank_pkg;

  // Width of every register in the bank and of the shared Din bus.
  localparam int DATA_W = 4;

  // Write arbiter states. The unused code 2'd3 is treated as illegal and the
  // FSM falls back to IDLE from it.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/reg4bit.sv
// ---------------------------------------------------------------------------
// reg4bit
// One enable-loaded register of the bank. Loads d on a rising clock edge
// when en is high; cleared asynchronously by an active-high reset.
// Ports:
//   clk   in   1       clock, rising edge
//   reset in   1       asynchronous, active-high reset
//   en    in   1       load enable
//   d     in   DATA_W  data input
//   q     out  DATA_W  stored value
// ---------------------------------------------------------------------------
module reg4bit
  import reg_bank_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  // Plain load-enable register; holds its value whenever en is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin search. Starting at ptr and ascending (wrapping
// from NREQ-1 back to 0), the first requester with its req bit set wins.
// Ports:
//   req   in   NREQ  request vector
//   ptr   in   IW    highest-priority requester index (must be < NREQ)
//   valid out  1     at least one request is pending
//   idx   out  IW    index of the winning requester (0 when valid is low)
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  // One extra bit so ptr + offset never overflows before the wrap.
  logic [IW:0] cand;

  // Walk the candidates in priority order: offset k from ptr, reduced
  // modulo NREQ. The inner loop turns the candidate number into a constant
  // bit select so no variable-width indexing is needed. The first hit
  // freezes valid, which blocks every later candidate.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NREQ)) begin
        cand = cand - (IW+1)'(NREQ);
      end
      for (int j = 0; j < NREQ; j++) begin
        if (!valid && (cand == (IW+1)'(j)) && req[j]) begin
          valid = 1'b1;
          idx   = IW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/reg_bank_wr_arbiter.sv
// ---------------------------------------------------------------------------
// reg_bank_wr_arbiter
// Sole writer of a bank of NREG 4-bit registers, shared among NREQ
// requesters with round-robin arbitration and a req/ack handshake.
// Each write walks IDLE -> WRITE -> DONE -> IDLE: the winner's addr and
// wdata are latched in IDLE, the one-hot reg_en pulses in WRITE, and ack
// (plus err for an out-of-range address) pulses in DONE.
// Ports:
//   clk      in   1            clock, rising edge
//   reset_n  in   1            asynchronous, active-low reset
//   req      in   NREQ         write requests, held until ack
//   addr     in   NREQ*AW      per-requester register index, slice i*AW +: AW
//   wdata    in   NREQ*DATA_W  per-requester write data, slice i*4 +: 4
//   ack      out  NREQ         one-cycle completion pulse to the winner
//   err      out  1            pulses with ack when the latched addr >= NREG
//   reg_en   out  NREG         one-hot load enable to the bank
//   reg_din  out  DATA_W       shared Din bus to the bank
//   busy     out  1            high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module reg_bank_wr_arbiter
  import reg_bank_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int NREG = 4,
  parameter int AW   = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*AW-1:0]       addr,
  input  logic [NREQ*DATA_W-1:0]   wdata,
  output logic [NREQ-1:0]          ack,
  output logic                     err,
  output logic [NREG-1:0]          reg_en,
  output logic [DATA_W-1:0]        reg_din,
  output logic                     busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e            state;
  state_e            state_next;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     gnt_idx;
  logic [AW-1:0]     addr_q;
  logic [DATA_W-1:0] data_q;

  logic              arb_valid;
  logic [IW-1:0]     arb_idx;
  logic [AW-1:0]     addr_sel;
  logic [DATA_W-1:0] data_sel;
  logic              addr_oob;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_arbiter (
    .req   (req),
    .ptr   (rr_ptr),
    .valid (arb_valid),
    .idx   (arb_idx)
  );

  // Pick the winner's address and data slices. Looping over constant
  // slices keeps every part-select static.
  always_comb begin
    addr_sel = '0;
    data_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_idx == IW'(i)) begin
        addr_sel = addr[i*AW +: AW];
        data_sel = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Registers: FSM state, the latched transaction and the round-robin
  // pointer. The transaction is captured only in IDLE, so requests seen in
  // WRITE or DONE never start a second write. The pointer advances past
  // the winner only once the write completes, so an aborted write leaves
  // fairness untouched (reset clears it anyway).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      gnt_idx <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state <= state_next;
      if ((state == IDLE) && arb_valid) begin
        gnt_idx <= arb_idx;
        addr_q  <= addr_sel;
        data_q  <= data_sel;
      end
      if (state == DONE) begin
        rr_ptr <= (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  // An address beyond the populated bank becomes a no-op write that is
  // still acknowledged, flagged with err.
  assign addr_oob = 32'(addr_q) >= 32'(NREG);

  // Next-state and output decode. All outputs come from registers only, so
  // they all fall to zero the moment reset is asserted. reg_din simply
  // mirrors data_q in every state; reg_en alone qualifies the bank write.
  always_comb begin
    state_next = state;
    reg_en     = '0;
    ack        = '0;
    err        = 1'b0;
    busy       = (state != IDLE);
    reg_din    = data_q;
    case (state)
      IDLE: begin
        if (arb_valid) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        for (int i = 0; i < NREG; i++) begin
          reg_en[i] = (addr_q == AW'(i));
        end
        state_next = DONE;
      end
      DONE: begin
        for (int i = 0; i < NREQ; i++) begin
          ack[i] = (gnt_idx == IW'(i));
        end
        err        = addr_oob;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
